// File: rtl/pipe_hazard_ctrl_if.sv
// Decoded-stage hazard information from the pipeline and the stall/flush/busy controls
// returned to it by pipe_hazard_ctrl.
interface pipe_hazard_ctrl_if;
  logic [4:0] RsD;
  logic [4:0] RtD;
  logic       UseRsD;
  logic       UseRtD;
  logic       BranchD;
  logic       MdUseD;
  logic       RegWriteE;
  logic       MemToRegE;
  logic [4:0] WriteRegE;
  logic       RegWriteM;
  logic       MemToRegM;
  logic [4:0] WriteRegM;
  logic       MdStartE;
  logic       MdIsDivE;
  logic       ExcReqM;
  logic       EretM;
  logic       StallF;
  logic       StallD;
  logic       FlushD;
  logic       FlushE;
  logic       FlushM;
  logic       MdBusy;
  logic [3:0] MdCount;

  modport master (
    output RsD, RtD, UseRsD, UseRtD, BranchD, MdUseD,
    output RegWriteE, MemToRegE, WriteRegE, RegWriteM, MemToRegM, WriteRegM,
    output MdStartE, MdIsDivE, ExcReqM, EretM,
    input  StallF, StallD, FlushD, FlushE, FlushM, MdBusy, MdCount
  );

  modport slave (
    input  RsD, RtD, UseRsD, UseRtD, BranchD, MdUseD,
    input  RegWriteE, MemToRegE, WriteRegE, RegWriteM, MemToRegM, WriteRegM,
    input  MdStartE, MdIsDivE, ExcReqM, EretM,
    output StallF, StallD, FlushD, FlushE, FlushM, MdBusy, MdCount
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard detection and stall/flush sequencing for the five-stage MIPS pipeline, including
// the multiply/divide busy counter.
module pipe_hazard_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic                clk,
  input  logic                reset,
  pipe_hazard_ctrl_if.slave   hz
);

  localparam logic [3:0] MultCnt = 4'(MULT_CYCLES);
  localparam logic [3:0] DivCnt  = 4'(DIV_CYCLES);

  logic [3:0] md_count_q, md_count_d;
  logic       md_busy;
  logic       lw_stall, br_stall, md_stall, stall, exc;
  logic       rs_hit_e, rt_hit_e, rs_hit_m, rt_hit_m;

  // Register 0 is never a real destination, so it never matches.
  function automatic logic dest_match(input logic we, input logic [4:0] wr,
                                      input logic [4:0] r);
    return we && (wr == r) && (r != 5'd0);
  endfunction

  always_comb begin
    rs_hit_e = dest_match(hz.RegWriteE, hz.WriteRegE, hz.RsD);
    rt_hit_e = dest_match(hz.RegWriteE, hz.WriteRegE, hz.RtD);
    rs_hit_m = dest_match(hz.RegWriteM, hz.WriteRegM, hz.RsD);
    rt_hit_m = dest_match(hz.RegWriteM, hz.WriteRegM, hz.RtD);

    md_busy  = (md_count_q != 4'd0);
    exc      = hz.ExcReqM || hz.EretM;

    lw_stall = hz.MemToRegE && ((hz.UseRsD && rs_hit_e) || (hz.UseRtD && rt_hit_e));
    br_stall = hz.BranchD && (rs_hit_e || rt_hit_e ||
                              (hz.MemToRegM && (rs_hit_m || rt_hit_m)));
    md_stall = hz.MdUseD && (md_busy || hz.MdStartE);
    stall    = lw_stall || br_stall || md_stall;
  end

  // An exception flushes everything and overrides any stall.
  assign hz.StallF  = stall && !exc;
  assign hz.StallD  = stall && !exc;
  assign hz.FlushE  = stall || exc;
  assign hz.FlushD  = exc;
  assign hz.FlushM  = exc;
  assign hz.MdBusy  = md_busy;
  assign hz.MdCount = md_count_q;

  // A start whose E instruction is being flushed is ignored; a running op keeps counting.
  always_comb begin
    md_count_d = md_count_q;
    if (hz.MdStartE && !exc) begin
      md_count_d = hz.MdIsDivE ? DivCnt : MultCnt;
    end else if (md_busy) begin
      md_count_d = md_count_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      md_count_q <= 4'd0;
    end else begin
      md_count_q <= md_count_d;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus randomized cycles checked
// against a cycle-indexed reference model of the hazard rules and the md busy window.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp  = 0;
  int   n_fail = 0;

  // Model: the md unit is described by when its last accepted start happened and how long it is.
  int cyc      = 0;
  int md_k     = 0;
  int md_n     = 0;
  bit md_valid = 0;

  pipe_hazard_ctrl_if hz();

  pipe_hazard_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] get_obs();
    return {hz.StallF, hz.StallD, hz.FlushD, hz.FlushE, hz.FlushM, hz.MdBusy, hz.MdCount};
  endfunction

  function automatic int exp_count();
    int d;
    if (!md_valid) return 0;
    d = cyc - md_k;
    if (d >= 1 && d <= md_n) return md_n - d + 1;
    return 0;
  endfunction

  function automatic bit hit(input bit we, input int wr, input int r);
    return we && wr == r && r != 0;
  endfunction

  function automatic logic [9:0] model_out();
    int cnt;
    bit lw, br, md, st, ex;
    cnt = exp_count();
    lw  = hz.MemToRegE && ((hz.UseRsD && hit(hz.RegWriteE, hz.WriteRegE, hz.RsD)) ||
                           (hz.UseRtD && hit(hz.RegWriteE, hz.WriteRegE, hz.RtD)));
    br  = hz.BranchD && (hit(hz.RegWriteE, hz.WriteRegE, hz.RsD) ||
                         hit(hz.RegWriteE, hz.WriteRegE, hz.RtD) ||
                         (hz.MemToRegM && (hit(hz.RegWriteM, hz.WriteRegM, hz.RsD) ||
                                           hit(hz.RegWriteM, hz.WriteRegM, hz.RtD))));
    md  = hz.MdUseD && (cnt > 0 || hz.MdStartE);
    st  = lw || br || md;
    ex  = hz.ExcReqM || hz.EretM;
    return {st && !ex, st && !ex, ex, st || ex, ex, cnt > 0, 4'(cnt)};
  endfunction

  task automatic clear_inputs();
    hz.RsD = 0; hz.RtD = 0; hz.UseRsD = 0; hz.UseRtD = 0; hz.BranchD = 0; hz.MdUseD = 0;
    hz.RegWriteE = 0; hz.MemToRegE = 0; hz.WriteRegE = 0;
    hz.RegWriteM = 0; hz.MemToRegM = 0; hz.WriteRegM = 0;
    hz.MdStartE = 0; hz.MdIsDivE = 0; hz.ExcReqM = 0; hz.EretM = 0;
  endtask

  // Advance one clock; the model consumes the inputs present at that edge.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      md_valid = 0;
    end else if (hz.MdStartE && !(hz.ExcReqM || hz.EretM)) begin
      md_valid = 1;
      md_k     = cyc;
      md_n     = hz.MdIsDivE ? 10 : 5;
    end
    cyc++;
    #1;
  endtask

  task automatic drain();
    clear_inputs();
    repeat (16) tick();
  endtask

  task automatic test_reset();
    logic [9:0] obs;
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #4;
    obs = get_obs();
    n_cmp++;
    if (obs !== 10'b0) begin
      n_fail++;
      $display("FAIL reset: got %b want %b", obs, 10'b0);
    end
  endtask

  task automatic test_load_use();
    logic [9:0] obs;
    clear_inputs();
    hz.MemToRegE = 1; hz.RegWriteE = 1; hz.WriteRegE = 8; hz.RsD = 8; hz.UseRsD = 1;
    #4;
    obs = get_obs();
    n_cmp++;
    if (obs !== 10'b11_0_1_0_0_0000) begin
      n_fail++;
      $display("FAIL load_use: got %b want %b", obs, 10'b11_0_1_0_0_0000);
    end
    tick();
    // The load has moved to M behind a bubble: a non-branch consumer is forwarded.
    hz.MemToRegE = 0; hz.RegWriteE = 0; hz.WriteRegE = 0;
    hz.MemToRegM = 1; hz.RegWriteM = 1; hz.WriteRegM = 8;
    #4;
    obs = get_obs();
    n_cmp++;
    if (obs !== 10'b0) begin
      n_fail++;
      $display("FAIL load_use_one_cycle: got %b want %b", obs, 10'b0);
    end
    tick();
    clear_inputs();
    hz.MemToRegE = 1; hz.RegWriteE = 1; hz.WriteRegE = 0; hz.RsD = 0; hz.UseRsD = 1;
    #4;
    obs = get_obs();
    n_cmp++;
    if (obs !== 10'b0) begin
      n_fail++;
      $display("FAIL load_use_r0: got %b want %b", obs, 10'b0);
    end
    tick();
  endtask

  task automatic test_branch();
    logic [9:0] obs;
    logic [9:0] want [3];
    want[0] = 10'b11_0_1_0_0_0000;
    want[1] = 10'b11_0_1_0_0_0000;
    want[2] = 10'b0;
    for (int i = 0; i < 3; i++) begin
      clear_inputs();
      hz.BranchD = 1; hz.RtD = 9;
      if (i == 0) begin
        hz.RegWriteE = 1; hz.MemToRegE = 1; hz.WriteRegE = 9;
      end else if (i == 1) begin
        hz.RegWriteM = 1; hz.MemToRegM = 1; hz.WriteRegM = 9;
      end
      #4;
      obs = get_obs();
      n_cmp++;
      if (obs !== want[i]) begin
        n_fail++;
        $display("FAIL branch_lw[%0d]: got %b want %b", i, obs, want[i]);
      end
      tick();
    end
    // ALU producer: one stall in E, none once it reaches M.
    for (int i = 0; i < 2; i++) begin
      clear_inputs();
      hz.BranchD = 1; hz.RsD = 12;
      if (i == 0) begin
        hz.RegWriteE = 1; hz.WriteRegE = 12;
      end else begin
        hz.RegWriteM = 1; hz.WriteRegM = 12;
      end
      #4;
      obs = get_obs();
      n_cmp++;
      if (obs !== want[i == 0 ? 0 : 2]) begin
        n_fail++;
        $display("FAIL branch_alu[%0d]: got %b want %b", i, obs, want[i == 0 ? 0 : 2]);
      end
      tick();
    end
  endtask

  task automatic test_md(input bit is_div, input int n);
    logic [9:0] obs;
    logic [9:0] want;
    clear_inputs();
    hz.MdStartE = 1; hz.MdIsDivE = is_div; hz.MdUseD = 1;
    #4;
    obs = get_obs();
    n_cmp++;
    if (obs !== 10'b11_0_1_0_0_0000) begin
      n_fail++;
      $display("FAIL md_start(div=%0d): got %b want %b", is_div, obs, 10'b11_0_1_0_0_0000);
    end
    tick();
    hz.MdStartE = 0; hz.MdIsDivE = 0;
    for (int i = n; i >= 0; i--) begin
      #4;
      want = (i > 0) ? {6'b11_0_1_0_1, 4'(i)} : 10'b0;
      obs = get_obs();
      n_cmp++;
      if (obs !== want) begin
        n_fail++;
        $display("FAIL md_count(div=%0d,step=%0d): got %b want %b", is_div, i, obs, want);
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_exception();
    logic [9:0] obs;
    clear_inputs();
    hz.ExcReqM = 1; hz.MdStartE = 1; hz.MdIsDivE = 1; hz.MdUseD = 1;
    #4;
    obs = get_obs();
    n_cmp++;
    if (obs !== 10'b00_1_1_1_0_0000) begin
      n_fail++;
      $display("FAIL exc_start: got %b want %b", obs, 10'b00_1_1_1_0_0000);
    end
    tick();
    clear_inputs();
    #4;
    obs = get_obs();
    n_cmp++;
    if (obs !== 10'b0) begin
      n_fail++;
      $display("FAIL exc_start_suppressed: got %b want %b", obs, 10'b0);
    end
    hz.MdStartE = 1;
    tick();
    hz.MdStartE = 0; hz.MdUseD = 1; hz.ExcReqM = 1;
    #4;
    obs = get_obs();
    n_cmp++;
    if (obs !== 10'b00_1_1_1_1_0101) begin
      n_fail++;
      $display("FAIL exc_over_md: got %b want %b", obs, 10'b00_1_1_1_1_0101);
    end
    tick();
    hz.ExcReqM = 0; hz.EretM = 1;
    #4;
    obs = get_obs();
    n_cmp++;
    if (obs !== 10'b00_1_1_1_1_0100) begin
      n_fail++;
      $display("FAIL eret_over_md: got %b want %b", obs, 10'b00_1_1_1_1_0100);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    logic [9:0] obs;
    clear_inputs();
    hz.MdStartE = 1; hz.MdIsDivE = 1;
    tick();
    clear_inputs();
    repeat (4) tick();
    #4;
    obs = get_obs();
    n_cmp++;
    if (obs !== 10'b00_0_0_0_1_0110) begin
      n_fail++;
      $display("FAIL reset_mid_pre: got %b want %b", obs, 10'b00_0_0_0_1_0110);
    end
    reset = 1; hz.MdStartE = 1;
    tick();
    reset = 0; clear_inputs();
    #4;
    obs = get_obs();
    n_cmp++;
    if (obs !== 10'b0) begin
      n_fail++;
      $display("FAIL reset_mid: got %b want %b", obs, 10'b0);
    end
    hz.MdStartE = 1;
    tick();
    clear_inputs();
    #4;
    obs = get_obs();
    n_cmp++;
    if (obs !== 10'b00_0_0_0_1_0101) begin
      n_fail++;
      $display("FAIL reset_then_start: got %b want %b", obs, 10'b00_0_0_0_1_0101);
    end
    drain();
  endtask

  task automatic test_restart();
    logic [9:0] obs;
    clear_inputs();
    hz.MdStartE = 1;
    tick();
    clear_inputs();
    repeat (2) tick();
    #4;
    obs = get_obs();
    n_cmp++;
    if (obs[3:0] !== 4'd3) begin
      n_fail++;
      $display("FAIL restart_pre: got %0d want %0d", obs[3:0], 3);
    end
    hz.MdStartE = 1;
    tick();
    clear_inputs();
    #4;
    obs = get_obs();
    n_cmp++;
    if (obs !== 10'b00_0_0_0_1_0101) begin
      n_fail++;
      $display("FAIL restart: got %b want %b", obs, 10'b00_0_0_0_1_0101);
    end
    drain();
  endtask

  task automatic test_random();
    logic [9:0] obs;
    logic [9:0] want;
    for (int i = 0; i < 400; i++) begin
      hz.RsD       = 5'($urandom_range(0, 3));
      hz.RtD       = 5'($urandom_range(0, 3));
      hz.UseRsD    = 1'($urandom);
      hz.UseRtD    = 1'($urandom);
      hz.BranchD   = ($urandom_range(0, 3) == 0);
      hz.MdUseD    = ($urandom_range(0, 2) == 0);
      hz.RegWriteE = 1'($urandom);
      hz.MemToRegE = 1'($urandom);
      hz.WriteRegE = 5'($urandom_range(0, 3));
      hz.RegWriteM = 1'($urandom);
      hz.MemToRegM = 1'($urandom);
      hz.WriteRegM = 5'($urandom_range(0, 3));
      hz.MdStartE  = ($urandom_range(0, 9) == 0);
      hz.MdIsDivE  = 1'($urandom);
      hz.ExcReqM   = ($urandom_range(0, 11) == 0);
      hz.EretM     = ($urandom_range(0, 15) == 0);
      reset        = ($urandom_range(0, 59) == 0);
      #4;
      want = model_out();
      obs  = get_obs();
      n_cmp++;
      if (obs !== want) begin
        n_fail++;
        $display("FAIL random[%0d]: got %b want %b", i, obs, want);
      end
      tick();
    end
    reset = 0;
    clear_inputs();
  endtask

  initial begin
    reset = 1'b0;
    clear_inputs();
    #1;
    test_reset();
    test_load_use();
    test_branch();
    test_md(1'b1, 10);
    test_md(1'b0, 5);
    test_exception();
    test_reset_mid();
    test_restart();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard and pipeline-sequencing controller for the five-stage MIPS pipeline. Detects load-use, branch-operand and multiply/divide-unit hazards from decoded stage information, and drives the stall/flush controls of the F, D, E and M pipeline registers. `StallD` maps to the IF/ID `en` input, which holds while 1; `FlushD` maps to IF/ID `clr`. Owns the multiply/divide busy counter, so a single block sequences the HI/LO unit and the pipeline registers.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: busy cycles after a mult/multu start; legal range 1..15.
- `DIV_CYCLES`, default 10: busy cycles after a div/divu start; legal range 1..15.

Ports:
- `clk` in 1: single clock; all state updates on posedge.
- `reset` in 1: synchronous, active-high.
- `RsD`, `RtD` in 5: source register numbers of the instruction in D.
- `UseRsD`, `UseRtD` in 1: the instruction in D reads Rs / Rt in E or later.
- `BranchD` in 1: the instruction in D is a branch or jr/jalr and reads its operands in D.
- `MdUseD` in 1: the instruction in D is mult/div/mfhi/mflo/mthi/mtlo.
- `RegWriteE`, `MemToRegE` in 1, `WriteRegE` in 5: destination info of E.
- `RegWriteM`, `MemToRegM` in 1, `WriteRegM` in 5: destination info of M.
- `MdStartE` in 1: a mult/div instruction is in E this cycle; asserted for 1 cycle.
- `MdIsDivE` in 1: qualifies `MdStartE`; 1 means div/divu.
- `ExcReqM` in 1: an exception or interrupt is taken at M.
- `EretM` in 1: eret is in M.
- `StallF`, `StallD` out 1: hold the PC and IF/ID.
- `FlushD`, `FlushE`, `FlushM` out 1: clear IF/ID, ID/EX and EX/MEM.
- `MdBusy` out 1: the multiply/divide unit is busy.
- `MdCount` out 4: remaining busy cycles.

## Operation
- Register 0 never creates a hazard. Every destination match below also requires the corresponding `WriteReg` to be non-zero.
- `MatchE(r)` = `RegWriteE` && `WriteRegE`==r && r!=0. `MatchM(r)` is defined the same way using M-stage signals.
- `lwStall` = `MemToRegE` && ((`UseRsD` && `MatchE(RsD)`) || (`UseRtD` && `MatchE(RtD)`)).
- `brStall` = `BranchD` && (`MatchE(RsD)` || `MatchE(RtD)` || (`MemToRegM` && (`MatchM(RsD)` || `MatchM(RtD)`))).
- `mdStall` = `MdUseD` && (`MdBusy` || `MdStartE`).
- `stall` = `lwStall` || `brStall` || `mdStall`.
- `exc` = `ExcReqM` || `EretM`.

Outputs (all combinational from inputs and `MdCount`):
- `StallF` = `StallD` = `stall` && !`exc`.
- `FlushE` = `stall` || `exc`. The stall case inserts a bubble.
- `FlushD` = `FlushM` = `exc`.
- Exception/eret overrides every stall. It flushes D, E and M in the same cycle and never asserts a stall.
- `MdBusy` = (`MdCount` != 0).

Counter, registered; the first matching rule applies:
- `reset` → 0.
- `MdStartE` && !`exc` → `DIV_CYCLES` if `MdIsDivE`, else `MULT_CYCLES`. This also applies when the counter is already busy: the counter restarts.
- `MdStartE` && `exc` → start suppressed, because the E instruction is flushed. The counter behaves as if there were no start.
- `MdCount` != 0 → `MdCount` − 1.
- Otherwise → hold at 0.
- An exception does not abort a running operation; the counter keeps decrementing.

## Timing
- Reset: `MdCount`=0 and `MdBusy`=0 after the reset edge. With all inputs at 0, every output is 0.
- Stall and flush outputs respond in the same cycle as their causes (zero latency). They are applied by the pipeline registers at the next posedge.
- `MdStartE` in cycle k gives `MdCount`=N in cycle k+1, counting N, N−1 … 1 through cycle k+N. `MdCount`=0 and `MdBusy`=0 in cycle k+N+1.
- A dependent md-instruction in D stalls in cycles k..k+N and advances at the end of cycle k+N+1.
- A load-use stall lasts exactly 1 cycle.
- A branch depending on a load stalls 2 cycles: the E match, then the M match.
- A branch depending on an ALU op stalls 1 cycle.
- `reset` asserted mid-count clears the counter at that edge, regardless of `MdStartE`.

## Test plan
- **Load-use:** `MemToRegE`=1, `RegWriteE`=1, `WriteRegE`=8, `RsD`=8, `UseRsD`=1 → `StallF`=`StallD`=`FlushE`=1 and `FlushD`=0. Repeat with `WriteRegE`=0 → all outputs 0.
- **Branch after lw:** `BranchD`=1, `RtD`=9, lw to $9 in E → stall. Next cycle the same lw is in M with `MemToRegM`=1 → stall again. Third cycle → no stall.
- **Divide:** pulse `MdStartE`=1 with `MdIsDivE`=1 → `MdCount` reads 10, 9, … 1, 0 on the following cycles. With `MdUseD`=1 held throughout, `StallD`=1 until the cycle `MdCount` reaches 0. Repeat with mult → count starts at 5.
- **Exception override:** `mdStall` active and `ExcReqM`=1 → `StallF`=`StallD`=0 and `FlushD`=`FlushE`=`FlushM`=1. Same-cycle `MdStartE` → `MdCount` stays 0.
- **Reset mid-count:** `MdCount`=6, then `reset`=1 for one edge → `MdCount`=0 and `MdBusy`=0. A new start after reset loads normally.
- **Restart:** `MdStartE` (mult) while `MdCount`=3 → `MdCount`=5 on the next cycle.
